// File: rtl/biquad_datapath.sv
`default_nettype none
// ============================================================================
// Module   : biquad_datapath
// Purpose  : Multiply-accumulate datapath for a direct-form-I biquad IIR
//            section. An external sequencer steps mem_dir through the five
//            operand/coefficient pairs and strobes the multiplier,
//            accumulator, history and output registers. The feedback
//            coefficients a1/a2 are held pre-negated, so the datapath only
//            ever adds.
//
// Ports    : clk, reset            clock, synchronous active-high reset
//            x_in[13:0]            signed ADC sample
//            mult_reset/enable     product register control
//            acc_reset/enable      accumulator control
//            output_reg_enable     load y_out from the scaled accumulator
//            x_mem_enable          shift the x history (xs -> xm1 -> xm2)
//            y_mem_enable          shift the y history (y_out -> yh -> yd2)
//            mem_dir[2:0]          operand/coefficient select
//            coef_we/addr/data     Q2.14 coefficient write port (addr 0..4)
//            y_out[15:0]           signed filtered sample
//            y_valid               one-cycle strobe after y_out updates
//
// Config   : BIQUAD_DP_SAT_EN  defined   -> scaled output saturates
//                              undefined -> scaled output wraps (low 16 bits)
//
// Revision : 1.0  initial release
// ============================================================================
module biquad_datapath (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [13:0] x_in,
  input  logic               mult_reset,
  input  logic               mult_enable,
  input  logic               acc_reset,
  input  logic               acc_enable,
  input  logic               output_reg_enable,
  input  logic               x_mem_enable,
  input  logic               y_mem_enable,
  input  logic [2:0]         mem_dir,
  input  logic               coef_we,
  input  logic [2:0]         coef_addr,
  input  logic signed [15:0] coef_data,
  output logic signed [15:0] y_out,
  output logic               y_valid
);

  localparam int C_X_W    = 14;
  localparam int C_D_W    = 16;
  localparam int C_P_W    = 30;
  localparam int C_ACC_W  = 34;
  localparam int C_FRAC_W = 14;
  localparam int C_N_COEF = 5;

  // Coefficient bank: 0=b0 1=b1 2=b2 3=-a1 4=-a2
  logic signed [C_D_W-1:0]   coef_q [C_N_COEF];

  logic signed [C_X_W-1:0]   xs_q, xm1_q, xm2_q;
  logic signed [C_D_W-1:0]   yh_q, yd2_q;
  logic signed [C_P_W-1:0]   p_q, p_d;
  logic signed [C_ACC_W-1:0] acc_q, acc_d;
  logic signed [C_D_W-1:0]   y_out_q, y_out_d;
  logic                      y_valid_q;

  logic signed [C_D_W-1:0]   w_operand;
  logic signed [C_D_W-1:0]   w_coef;
  logic signed [C_P_W-1:0]   w_operand_ext;
  logic signed [C_P_W-1:0]   w_coef_ext;

  // --------------------------------------------------------------------------
  // Operand / coefficient select. Codes 5..7 fall back to x_in / b0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_operand = {{(C_D_W-C_X_W){x_in[C_X_W-1]}}, x_in};
    w_coef    = coef_q[0];
    case (mem_dir)
      3'd1: begin
        w_operand = {{(C_D_W-C_X_W){xm1_q[C_X_W-1]}}, xm1_q};
        w_coef    = coef_q[1];
      end
      3'd2: begin
        w_operand = {{(C_D_W-C_X_W){xm2_q[C_X_W-1]}}, xm2_q};
        w_coef    = coef_q[2];
      end
      3'd3: begin
        w_operand = y_out_q;
        w_coef    = coef_q[3];
      end
      3'd4: begin
        w_operand = yd2_q;
        w_coef    = coef_q[4];
      end
      default: ;
    endcase
  end

  // Multiplying the operands sign-extended to the product width yields the
  // low 30 bits of the full 32-bit product directly, which is exactly what
  // the product register keeps.
  assign w_operand_ext = {{(C_P_W-C_D_W){w_operand[C_D_W-1]}}, w_operand};
  assign w_coef_ext    = {{(C_P_W-C_D_W){w_coef[C_D_W-1]}}, w_coef};

  always_comb begin
    p_d = p_q;
    if (mult_reset) begin
      p_d = '0;
    end else if (mult_enable) begin
      p_d = w_operand_ext * w_coef_ext;
    end
  end

  // Accumulator wraps modulo 2^34.
  always_comb begin
    acc_d = acc_q;
    if (acc_reset) begin
      acc_d = '0;
    end else if (acc_enable) begin
      acc_d = acc_q + {{(C_ACC_W-C_P_W){p_q[C_P_W-1]}}, p_q};
    end
  end

  // --------------------------------------------------------------------------
  // Output scaling: acc >>> 14, narrowed to 16 bits. Uses acc_q, i.e. the
  // value before any acc_reset landing on the same edge.
  // --------------------------------------------------------------------------
`ifdef BIQUAD_DP_SAT_EN
  logic signed [C_ACC_W-C_FRAC_W-1:0] w_scaled;
  logic                               w_ovf;

  assign w_scaled = acc_q[C_ACC_W-1:C_FRAC_W];
  // Out of 16-bit range whenever the bits above the result sign disagree.
  assign w_ovf    = (w_scaled[C_ACC_W-C_FRAC_W-1:C_D_W-1] != '0) &&
                    (w_scaled[C_ACC_W-C_FRAC_W-1:C_D_W-1] != '1);

  always_comb begin
    y_out_d = y_out_q;
    if (output_reg_enable) begin
      if (w_ovf) begin
        y_out_d = w_scaled[C_ACC_W-C_FRAC_W-1] ? 16'sh8000 : 16'sh7fff;
      end else begin
        y_out_d = w_scaled[C_D_W-1:0];
      end
    end
  end
`else
  always_comb begin
    y_out_d = y_out_q;
    if (output_reg_enable) begin
      y_out_d = acc_q[C_FRAC_W+C_D_W-1:C_FRAC_W];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State registers; reset overrides every strobe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_N_COEF; i++) begin
        coef_q[i] <= '0;
      end
      p_q       <= '0;
      acc_q     <= '0;
      xs_q      <= '0;
      xm1_q     <= '0;
      xm2_q     <= '0;
      yh_q      <= '0;
      yd2_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      // Addresses 5..7 match no entry and are therefore ignored.
      for (int i = 0; i < C_N_COEF; i++) begin
        if (coef_we && (coef_addr == 3'(i))) begin
          coef_q[i] <= coef_data;
        end
      end
      p_q       <= p_d;
      acc_q     <= acc_d;
      y_out_q   <= y_out_d;
      y_valid_q <= output_reg_enable;
      if (x_mem_enable) begin
        xs_q  <= x_in;
        xm1_q <= xs_q;
        xm2_q <= xm1_q;
      end
      if (y_mem_enable) begin
        yh_q  <= y_out_q;
        yd2_q <= yh_q;
      end
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_biquad_datapath
// Purpose  : Self-checking bench for biquad_datapath. A sequencer task drives
//            7-cycle frames (or 6-cycle frames with the output load merged
//            into the next frame start) and compares every output against a
//            difference-equation model of the filter.
// Revision : 1.0  initial release
// ============================================================================
module tb_biquad_datapath;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [13:0] x_in;
  logic               mult_reset, mult_enable, acc_reset, acc_enable;
  logic               output_reg_enable, x_mem_enable, y_mem_enable;
  logic [2:0]         mem_dir;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [15:0] y_out;
  logic               y_valid;

  always #5 clk = ~clk;

  biquad_datapath dut (
    .clk               (clk),
    .reset             (reset),
    .x_in              (x_in),
    .mult_reset        (mult_reset),
    .mult_enable       (mult_enable),
    .acc_reset         (acc_reset),
    .acc_enable        (acc_enable),
    .output_reg_enable (output_reg_enable),
    .x_mem_enable      (x_mem_enable),
    .y_mem_enable      (y_mem_enable),
    .mem_dir           (mem_dir),
    .coef_we           (coef_we),
    .coef_addr         (coef_addr),
    .coef_data         (coef_data),
    .y_out             (y_out),
    .y_valid           (y_valid)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: y[n] = sum(c_k * v_k), each product kept to 30 bits,
  // sum modulo 2^34, then >>>14 and narrowed to 16 bits.
  // --------------------------------------------------------------------------
  longint m_cf [5];
  longint m_x  [3];
  longint m_y1, m_y2;

  function automatic longint wrap_s(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint narrow(input longint v);
`ifdef BIQUAD_DP_SAT_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return wrap_s(v, 16);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_cf[i] = 0;
    for (int i = 0; i < 3; i++) m_x[i] = 0;
    m_y1 = 0;
    m_y2 = 0;
  endtask

  function automatic longint model_frame(input longint x);
    longint sum;
    longint y;
    m_x[2] = m_x[1];
    m_x[1] = m_x[0];
    m_x[0] = x;
    sum = wrap_s(m_cf[0] * m_x[0], 30) + wrap_s(m_cf[1] * m_x[1], 30)
        + wrap_s(m_cf[2] * m_x[2], 30) + wrap_s(m_cf[3] * m_y1, 30)
        + wrap_s(m_cf[4] * m_y2, 30);
    sum = wrap_s(sum, 34);
    y = narrow(sum >>> 14);
    m_y2 = m_y1;
    m_y1 = y;
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  longint stim [$];
  longint got  [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mult_reset = 0; mult_enable = 0; acc_reset = 0; acc_enable = 0;
    output_reg_enable = 0; x_mem_enable = 0; y_mem_enable = 0;
    mem_dir = 3'd0; coef_we = 0; coef_addr = 3'd0; coef_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    model_reset();
  endtask

  task automatic coef_write(input int addr, input longint d);
    idle();
    coef_we   = 1;
    coef_addr = 3'(addr);
    coef_data = 16'(d);
    tick();
    idle();
    if (addr <= 4) m_cf[addr] = wrap_s(d, 16);
  endtask

  // Runs every sample in stim as one frame. In merged mode the output load
  // of frame k-1 shares its edge with the start (acc_reset, sample capture,
  // first multiply) of frame k.
  task automatic run_frames(input bit merged);
    int     n;
    longint e;
    longint e_prev;
    logic [2:0] v;
    n = stim.size();
    e_prev = 0;
    got.delete();
    for (int k = 0; k < n; k++) begin
      e = model_frame(stim[k]);
      for (int c = 0; c < 7; c++) begin
        if (merged && c == 6 && k < n - 1) continue;
        idle();
        case (c)
          0: begin
            v = 3'($urandom_range(4, 7));
            mem_dir = (v == 3'd4) ? 3'd0 : v;
            mult_enable = 1; x_mem_enable = 1; acc_reset = 1;
            x_in = 14'(stim[k]);
            output_reg_enable = merged && (k > 0);
          end
          1: begin
            mem_dir = 3'd1; mult_enable = 1; acc_enable = 1; y_mem_enable = 1;
          end
          2, 3, 4: begin
            mem_dir = 3'(c); mult_enable = 1; acc_enable = 1;
          end
          5: begin
            mem_dir = 3'($urandom_range(5, 7)); acc_enable = 1; mult_reset = 1;
          end
          default: output_reg_enable = 1;
        endcase
        tick();
        if (output_reg_enable) begin
          got.push_back(y_out);
          chk("y_out", y_out, (c == 0) ? e_prev : e);
          chk("y_valid_hi", y_valid, 1);
        end else if (c == 1 || (c == 0 && !merged)) begin
          chk("y_valid_lo", y_valid, 0);
        end
      end
      e_prev = e;
    end
    idle();
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1;
    x_in  = '0;
    idle();
    model_reset();
    tick();
    tick();
    reset = 0;
    chk("rst_y_out", y_out, 0);
    chk("rst_y_valid", y_valid, 0);

    // Unity gain: b0 = 1.0
    do_reset();
    coef_write(0, 16384);
    stim = '{1000};
    run_frames(0);
    chk("unity_y", got[0], 1000);

    // Three-tap average, b0=b1=b2=0.5
    do_reset();
    coef_write(0, 8192);
    coef_write(1, 8192);
    coef_write(2, 8192);
    stim = '{100, 200, 300};
    run_frames(0);
    chk("fir_y0", got[0], 50);
    chk("fir_y1", got[1], 150);
    chk("fir_y2", got[2], 300);

    // Single pole at 0.5, impulse response, merged frames
    do_reset();
    coef_write(0, 16384);
    coef_write(3, 8192);
    stim = '{1000, 0, 0, 0};
    run_frames(1);
    chk("pole_y0", got[0], 1000);
    chk("pole_y1", got[1], 500);
    chk("pole_y2", got[2], 250);
    chk("pole_y3", got[3], 125);

    // Output range overflow
    do_reset();
    coef_write(0, -32768);
    coef_write(1, -32768);
    coef_write(2, -32768);
    stim = '{-8192, -8192, -8192};
    run_frames(0);
    chk("ovf_y0", got[0], 16384);
`ifdef BIQUAD_DP_SAT_EN
    chk("ovf_y1", got[1], 32767);
    chk("ovf_y2", got[2], 32767);
`else
    chk("ovf_y1", got[1], -32768);
    chk("ovf_y2", got[2], -16384);
`endif

    // Reset in the middle of an accumulation
    do_reset();
    for (int i = 0; i < 5; i++) coef_write(i, 4000 + i);
    idle();
    x_in = 14'sd1234; mult_enable = 1; x_mem_enable = 1; acc_reset = 1;
    tick();
    idle();
    mem_dir = 3'd1; mult_enable = 1; acc_enable = 1;
    tick();
    idle();
    reset = 1; output_reg_enable = 1; acc_enable = 1; coef_we = 1;
    coef_addr = 3'd0; coef_data = 16'sd9999;
    tick();
    reset = 0;
    idle();
    model_reset();
    chk("midrst_y_out", y_out, 0);
    chk("midrst_y_valid", y_valid, 0);
    stim = '{0};
    run_frames(0);
    chk("midrst_frame0", got[0], 0);
    stim = '{3000, -2000};
    run_frames(0);
    chk("nocoef_y1", got[1], 0);
    coef_write(5, 12345);
    coef_write(6, -777);
    coef_write(7, 16384);
    stim = '{4000};
    run_frames(0);
    chk("badaddr_y", got[0], 0);

    // Randomized coefficient sets and samples
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 5; i++) begin
        if (r < 3) coef_write(i, longint'($urandom_range(0, 16383)) - 8192);
        else       coef_write(i, longint'($urandom_range(0, 65535)) - 32768);
      end
      for (int i = 0; i < 3; i++) begin
        coef_write($urandom_range(0, 7), longint'($urandom_range(0, 65535)) - 32768);
      end
      stim.delete();
      for (int k = 0; k < 16; k++) begin
        stim.push_back(longint'($urandom_range(0, 16383)) - 8192);
      end
      run_frames(r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
